// File: rtl/bus_des_q_pkg.sv
// Shared definitions for the bus deserializer: BUS field layout, FSM encoding
// and the transaction header record carried through the completion queue.
package bus_des_q_pkg;

  localparam int PADR_W = 15;
  localparam int RET_W  = 4;
  localparam int DEST_W = 4;
  localparam int SIZE_W = 16;

  localparam int VALID_O = 0;
  localparam int PADR_O  = 1;
  localparam int DATA_O  = 16;

  function automatic int ret_o(input int beat_w);
    return DATA_O + beat_w;
  endfunction

  function automatic int dest_o(input int beat_w);
    return ret_o(beat_w) + RET_W;
  endfunction

  function automatic int rw_o(input int beat_w);
    return dest_o(beat_w) + DEST_W;
  endfunction

  function automatic int size_o(input int beat_w);
    return rw_o(beat_w) + 1;
  endfunction

  // The bus is 16 bits wider than the defined fields; the top bits are reserved.
  function automatic int bus_w(input int beat_w);
    return 57 + beat_w;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  typedef struct packed {
    logic [PADR_W-1:0] padr;
    logic [RET_W-1:0]  ret;
    logic [DEST_W-1:0] dest;
    logic              rw;
    logic [SIZE_W-1:0] mask;
  } txn_hdr_t;

endpackage

// File: rtl/bus_des_fifo.sv
// DEPTH-entry synchronous FIFO of flattened transaction records. The head is
// presented combinationally from storage and reads as zero while empty.
module bus_des_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);

  // Storage, pointers and occupancy; push and pop in one cycle keep count.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[tail] <= din;
        tail      <= wrap_inc(tail);
      end
      if (do_pop) begin
        head <= wrap_inc(head);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/bus_des_q.sv
// Bus deserializer: collects a granted multi-beat transfer into one line and
// queues completed transactions for the endpoint.
module bus_des_q
  import bus_des_q_pkg::*;
#(
  parameter logic [3:0] LOC = 4'd0,
  parameter int BEAT_W = 32,
  parameter int NBEATS = 4,
  parameter int DEPTH  = 2
) (
  input  logic                       clk_bus,
  input  logic                       rst,
  inout  wire  [bus_w(BEAT_W)-1:0]   BUS,
  input  logic                       setReciever,
  output logic                       free_bau,
  input  logic                       read,
  output logic                       full,
  output logic [PADR_W-1:0]          pAdr,
  output logic [NBEATS*BEAT_W-1:0]   data,
  output logic [RET_W-1:0]           ret,
  output logic [DEST_W-1:0]          dest,
  output logic                       rw,
  output logic [SIZE_W-1:0]          size,
  output logic                       err
);

  localparam int LINE_W = NBEATS * BEAT_W;
  localparam int HDR_W  = $bits(txn_hdr_t);
  localparam int REC_W  = HDR_W + LINE_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BUS_W  = bus_w(BEAT_W);
  localparam int SO     = size_o(BEAT_W);

  logic              valid_bus;
  logic [PADR_W-1:0] padr_bus;
  logic [BEAT_W-1:0] data_bus;
  logic [RET_W-1:0]  ret_bus;
  logic [DEST_W-1:0] dest_bus;
  logic              rw_bus;
  logic [SIZE_W-1:0] size_bus;
  logic              unused_bits;

  assign valid_bus   = BUS[VALID_O];
  assign padr_bus    = BUS[PADR_O +: PADR_W];
  assign data_bus    = BUS[DATA_O +: BEAT_W];
  assign ret_bus     = BUS[ret_o(BEAT_W) +: RET_W];
  assign dest_bus    = BUS[dest_o(BEAT_W) +: DEST_W];
  assign rw_bus      = BUS[rw_o(BEAT_W)];
  assign size_bus    = BUS[SO +: SIZE_W];
  assign unused_bits = ^{BUS[BUS_W-1:SO+SIZE_W], size_bus};

  state_t            state, state_n;
  logic              hdr_seen, hdr_seen_n;
  logic [NBEATS-1:0] rem, rem_n;
  logic [NBEATS-1:0] mask_v;
  logic [NBEATS-1:0] sel;
  logic [LINE_W-1:0] line, line_n;
  txn_hdr_t          hdr, hdr_n;
  logic              err_n;
  logic              push;
  logic [REC_W-1:0]  head_rec;
  logic [CNT_W-1:0]  count;
  txn_hdr_t          head_hdr;

  assign free_bau = (state == ST_IDLE) && (count < CNT_W'(DEPTH));

  // Next-state, line assembly and completion; each valid beat fills the lowest remaining slot.
  always_comb begin
    state_n    = state;
    hdr_seen_n = hdr_seen;
    rem_n      = rem;
    line_n     = line;
    hdr_n      = hdr;
    err_n      = err;
    push       = 1'b0;
    mask_v     = rem;
    sel        = '0;
    case (state)
      ST_IDLE: begin
        if (setReciever && free_bau) begin
          state_n    = ST_RECV;
          hdr_seen_n = 1'b0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (valid_bus) begin
          if (!hdr_seen) begin
            mask_v     = size_bus[NBEATS-1:0];
            line_n     = '0;
            hdr_n.padr = padr_bus;
            hdr_n.ret  = ret_bus;
            hdr_n.dest = dest_bus;
            hdr_n.rw   = rw_bus;
            hdr_n.mask = '0;
            hdr_n.mask[NBEATS-1:0] = size_bus[NBEATS-1:0];
            err_n      = err || (dest_bus != LOC);
          end else begin
            mask_v = rem;
          end
          sel = mask_v & ~(mask_v - NBEATS'(1));
          for (int i = 0; i < NBEATS; i++) begin
            line_n[i*BEAT_W +: BEAT_W] = sel[i] ? data_bus : line_n[i*BEAT_W +: BEAT_W];
          end
          rem_n      = mask_v & ~sel;
          hdr_seen_n = 1'b1;
          if (rem_n == '0) begin
            push    = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_RECV;
          end
        end else begin
          state_n = ST_RECV;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Assembly state registers; err is sticky until reset.
  always_ff @(posedge clk_bus) begin
    if (rst) begin
      state    <= ST_IDLE;
      hdr_seen <= 1'b0;
      rem      <= '0;
      line     <= '0;
      hdr      <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      hdr_seen <= hdr_seen_n;
      rem      <= rem_n;
      line     <= line_n;
      hdr      <= hdr_n;
      err      <= err_n;
    end
  end

  bus_des_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk_bus),
    .rst   (rst),
    .push  (push),
    .pop   (read),
    .din   ({hdr_n, line_n}),
    .dout  (head_rec),
    .count (count)
  );

  assign head_hdr = txn_hdr_t'(head_rec[REC_W-1 -: HDR_W]);
  assign full     = (count != '0);
  assign pAdr     = head_hdr.padr;
  assign data     = head_rec[LINE_W-1:0];
  assign ret      = head_hdr.ret;
  assign dest     = head_hdr.dest;
  assign rw       = head_hdr.rw;
  assign size     = head_hdr.mask << (SIZE_W - NBEATS);

endmodule
